// File: rtl/multicycle_proc.sv
// Multi-cycle MIPS-subset core: one instruction in flight, stepped through
// IF/ID/EX/MEM/WB over a single shared req/ready memory port.
module multicycle_proc #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic [ADDR_WIDTH-1:0] startPC,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWData,
    input  logic [31:0]           memRData,
    input  logic                  memReady,
    output logic [31:0]           dMemOut,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ORI  = 6'h0D,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_BEQ  = 6'h04,
                           OP_J     = 6'h02, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A, FN_SLL = 6'h00;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           ir_q, a_q, b_q, imm_q, alu_q, mdr_q, dmem_q;
    logic                  halted_q;
    logic [CNT_WIDTH-1:0]  retired_q;
    logic [31:0]           regs_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_dest;
    logic [31:0] alu_res;
    logic        alu_nop;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign wb_dest = (opcode == OP_RTYPE) ? rd : rt;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_nop = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_res = a_q + b_q;
                    FN_SUB:  alu_res = a_q - b_q;
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                    FN_SLL:  alu_res = b_q << shamt;
                    default: alu_nop = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_q;
            OP_ORI:                alu_res = a_q | imm_q;
            OP_BEQ, OP_J:          alu_res = '0;
            default:               alu_nop = 1'b1;
        endcase
    end

    // Port is driven straight from state so the request is live in the same cycle; reset forces it idle.
    always_comb begin
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        if (Reset_L) begin
            if (state_q == S_IF) begin
                memReq  = 1'b1;
                memAddr = pc_q;
            end else if (state_q == S_MEM) begin
                memReq   = 1'b1;
                memWe    = (opcode == OP_SW);
                memAddr  = ADDR_WIDTH'(alu_q);
                memWData = b_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= S_IF;
            pc_q      <= startPC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            dmem_q    <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
            // NOTE: the register file must come up zeroed, so it is reset like any flop rather than left as RAM.
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IF: if (memReady) begin
                    ir_q    <= memRData;
                    pc_q    <= pc_q + ADDR_WIDTH'(4);
                    state_q <= S_ID;
                end
                S_ID: begin
                    a_q   <= regs_q[rs];
                    b_q   <= regs_q[rt];
                    imm_q <= (opcode == OP_ORI) ? {16'b0, ir_q[15:0]}
                                                : {{16{ir_q[15]}}, ir_q[15:0]};
                    if (opcode == OP_HALT) begin
                        halted_q  <= 1'b1;
                        retired_q <= retired_q + CNT_WIDTH'(1);
                        state_q   <= S_HALT;
                    end else begin
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    if (opcode == OP_BEQ) begin
                        if (a_q == b_q) pc_q <= pc_q + ADDR_WIDTH'(imm_q << 2);
                        retired_q <= retired_q + CNT_WIDTH'(1);
                        state_q   <= S_IF;
                    end else if (opcode == OP_J) begin
                        pc_q <= ADDR_WIDTH'((32'(pc_q) & 32'hF000_0000) | {4'b0, ir_q[25:0], 2'b00});
                        retired_q <= retired_q + CNT_WIDTH'(1);
                        state_q   <= S_IF;
                    end else if (alu_nop) begin
                        retired_q <= retired_q + CNT_WIDTH'(1);
                        state_q   <= S_IF;
                    end else begin
                        alu_q   <= alu_res;
                        state_q <= (opcode == OP_LW || opcode == OP_SW) ? S_MEM : S_WB;
                    end
                end
                S_MEM: if (memReady) begin
                    if (opcode == OP_SW) begin
                        retired_q <= retired_q + CNT_WIDTH'(1);
                        state_q   <= S_IF;
                    end else begin
                        mdr_q   <= memRData;
                        dmem_q  <= memRData;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) regs_q[wb_dest] <= (opcode == OP_LW) ? mdr_q : alu_q;
                    retired_q <= retired_q + CNT_WIDTH'(1);
                    state_q   <= S_IF;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign dMemOut = dmem_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: doc/multicycle_proc.md
# multicycle_proc

Parametrised multi-cycle MIPS-subset core; next generation of the team's single-cycle processor. Executes each instruction over 3-5 state-machine steps through one shared memory port with a req/ready handshake, so instruction and data memory may have any latency. Contains its own 32x32 register file, instruction register and PC, and exposes load data, halt status and a retired-instruction count to the testbench.

## Interface
- ADDR_WIDTH, 32: width of PC and memAddr (≤32); upper PC bits truncated.
- CNT_WIDTH, 16: width of retired counter.
- CLK in 1: rising-edge clock for all state.
- Reset_L in 1: reset, asynchronous, active-low.
- startPC in ADDR_WIDTH: PC loaded on reset.
- memReq out 1: memory access request.
- memWe out 1: 1 = write (SW), 0 = read (fetch, LW).
- memAddr out ADDR_WIDTH: byte address (word-aligned by software).
- memWData out 32: store data.
- memRData in 32: read data, valid when memReady=1.
- memReady in 1: access completes at rising edge where memReq&memReady.
- dMemOut out 32: data of most recent completed LW.
- halted out 1: core stopped on HALT.
- retired out CNT_WIDTH: instructions completed, wraps.

## Operation
- Opcodes: R-type 0x00 (funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A signed, SLL 0x00 = rt<<shamt), ADDI 0x08 (sign-ext), ORI 0x0D (zero-ext), LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, HALT 0x3F. Any other opcode/funct: NOP.
- Arithmetic 32-bit, wraps, no overflow trap. r0 reads 0, writes ignored.
- States: IF, ID, EX, MEM, WB, HALT.
- IF: memReq=1, memWe=0, memAddr=PC; on ready: IR<=memRData, PC<=PC+4, →ID.
- ID: A<=R[rs], B<=R[rt], imm extended per opcode; HALT →HALT; else →EX.
- EX: ALUOut computed. BEQ: if A==B PC<=PC+(sext(imm)<<2); retire; →IF. J: PC<={PC[top 4 bits],imm26,2'b00} truncated to ADDR_WIDTH; retire; →IF. LW/SW: ALUOut=A+sext(imm); →MEM. NOP: retire; →IF. Others →WB.
- MEM: memReq=1, memAddr=ALUOut, memWe=(SW), memWData=B; on ready: SW retires →IF; LW: MDR<=memRData, dMemOut<=memRData →WB.
- WB: write R[rd] (R-type) or R[rt] (ADDI/ORI/LW) with ALUOut or MDR; retire; →IF.
- HALT: memReq=0, halted=1, retired incremented once on entry; stays until reset.

## Timing
- Reset (Reset_L=0, async): state=IF, PC=startPC, all GPRs=0, IR=0, dMemOut=0, halted=0, retired=0, memReq=0, memWe=0, memAddr=0, memWData=0 while asserted. First fetch request on first rising edge after release.
- memReq/memWe/memAddr/memWData are combinational from state and registers, held stable until the handshake edge; core never drops memReq before ready.
- Zero-wait memory (memReady constantly 1): BEQ/J/NOP 3 cycles, R-type/ADDI/ORI/SW 4, LW 5. Each cycle of memReady=0 adds exactly one cycle to IF or MEM.
- Register written in WB visible to ID of the next instruction (no hazards; one instruction in flight).
- Reset mid-transaction: memReq drops immediately, pending access abandoned, no register/memory state retained except memory contents.
- PC and branch/jump arithmetic modulo 2^ADDR_WIDTH.
- retired wraps from 2^CNT_WIDTH-1 to 0.

## Test plan
- Reset with startPC=0x40, memReady=1 -> first memAddr=0x40 with memReq=1; halted=0, retired=0, dMemOut=0.
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SW r3,0(r0); HALT -> memory write addr 0, data 2; retired=5; halted=1; total 4+4+4+4+2(IF,ID) cycles.
- Store 0xDEADBEEF at 0x100, LW r4,0x100(r0) with memReady low 3 cycles in MEM -> dMemOut=0xDEADBEEF exactly 3 cycles later than zero-wait; memAddr stable during wait.
- BEQ taken (r1=r2) offset +2 and not-taken -> next fetch PC+12 vs PC+4; J 0x000010 from 0x1000 -> fetch 0x40.
- SLL r5,r1,4 with r1=1, SLT r6,r2,r1 with r2=-3 -> r5=16, r6=1; write to r0 -> r0 still reads 0.
- Reset_L pulsed low while in MEM wait -> memReq=0 same cycle, PC=startPC, retired=0, refetch from startPC.
